// File: rtl/sa_step_controller.sv
// Job sequencer for the systolic array: per tile it runs weight load,
// a fixed-length compute phase and an output drain, then pulses done.
module sa_step_controller #(
    parameter int NUM_STEPS    = 9,
    parameter int LOAD_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int TILE_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              stall,
    output logic              busy,
    output logic [3:0]        cnt,
    output logic              sa_reg_en,
    output logic              w_load,
    output logic              acc_clr,
    output logic              out_valid,
    output logic [TILE_W-1:0] tile_idx,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int PH_W = 8;

    // Register-enable pattern indexed by step; steps 9..15 stay disabled.
    localparam logic [15:0] PATTERN = 16'h01A5;

    logic [2:0]        state;
    logic [3:0]        cnt_q;
    logic [PH_W-1:0]   phase;
    logic [TILE_W-1:0] tiles;
    logic [TILE_W-1:0] tile_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt_q  <= '0;
            phase  <= '0;
            tiles  <= '0;
            tile_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tiles  <= num_tiles;
                        tile_q <= '0;
                        phase  <= '0;
                        cnt_q  <= '0;
                        state  <= (num_tiles == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!stall) begin
                        if (phase == PH_W'(LOAD_CYCLES - 1)) begin
                            phase <= '0;
                            cnt_q <= '0;
                            state <= S_RUN;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (cnt_q == 4'(NUM_STEPS - 1)) begin
                            cnt_q <= '0;
                            phase <= '0;
                            state <= S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        if (phase == PH_W'(DRAIN_CYCLES - 1)) begin
                            phase <= '0;
                            // tiles is nonzero here, so tiles-1 cannot underflow
                            if (tile_q == tiles - TILE_W'(1)) begin
                                state <= S_DONE;
                            end else begin
                                tile_q <= tile_q + 1'b1;
                                state  <= S_LOAD;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        cnt       = '0;
        sa_reg_en = 1'b0;
        w_load    = 1'b0;
        acc_clr   = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            S_LOAD: begin
                busy   = 1'b1;
                w_load = ~stall;
            end
            S_RUN: begin
                busy      = 1'b1;
                cnt       = cnt_q;
                sa_reg_en = PATTERN[cnt_q] & ~stall;
                acc_clr   = (cnt_q == 4'd0) & ~stall;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = ~stall;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign tile_idx = tile_q;

endmodule

// File: tb/tb_sa_step_controller.sv
// Bench for sa_step_controller: a job-level model expands each accepted
// job into its expected per-cycle output sequence; a monitor compares.
module tb_sa_step_controller;

    localparam int NS = 9;
    localparam int LC = 2;
    localparam int DC = 3;

    typedef struct packed {
        logic       busy;
        logic [3:0] cnt;
        logic       sa_reg_en;
        logic       w_load;
        logic       acc_clr;
        logic       out_valid;
        logic [3:0] tile_idx;
        logic       done;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] num_tiles;
    logic       stall;
    logic       busy;
    logic [3:0] cnt;
    logic       sa_reg_en;
    logic       w_load;
    logic       acc_clr;
    logic       out_valid;
    logic [3:0] tile_idx;
    logic       done;

    obs_t       seq[$];
    obs_t       sb[$];
    logic [3:0] last_tile;
    bit         primed;
    bit         pat[NS];
    int         checks;
    int         fails;
    int         jobs_expected;
    int         done_seen;

    sa_step_controller dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_tiles (num_tiles),
        .stall     (stall),
        .busy      (busy),
        .cnt       (cnt),
        .sa_reg_en (sa_reg_en),
        .w_load    (w_load),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .tile_idx  (tile_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One entry per non-stalled cycle of the job, in order.
    task automatic build(input logic [3:0] n);
        obs_t e;
        jobs_expected++;
        last_tile = '0;
        for (int t = 0; t < int'(n); t++) begin
            for (int i = 0; i < LC; i++) begin
                e = '0;
                e.busy = 1'b1;
                e.w_load = 1'b1;
                e.tile_idx = 4'(t);
                seq.push_back(e);
            end
            for (int k = 0; k < NS; k++) begin
                e = '0;
                e.busy = 1'b1;
                e.cnt = 4'(k);
                e.sa_reg_en = pat[k];
                e.acc_clr = (k == 0);
                e.tile_idx = 4'(t);
                seq.push_back(e);
            end
            for (int i = 0; i < DC; i++) begin
                e = '0;
                e.busy = 1'b1;
                e.out_valid = 1'b1;
                e.tile_idx = 4'(t);
                seq.push_back(e);
            end
        end
        e = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        e.tile_idx = (n == 4'd0) ? 4'd0 : n - 4'd1;
        seq.push_back(e);
    endtask

    task automatic tick(input logic st, input logic [3:0] n,
                        input logic stl, input logic rst);
        obs_t e;
        start = st;
        num_tiles = n;
        stall = stl;
        reset = rst;
        if (seq.size() == 0) begin
            e = '0;
            e.tile_idx = last_tile;
        end else begin
            e = seq[0];
            if (stl && !e.done) begin
                e.w_load = 1'b0;
                e.sa_reg_en = 1'b0;
                e.acc_clr = 1'b0;
                e.out_valid = 1'b0;
            end
        end
        if (primed) sb.push_back(e);
        if (rst) begin
            if (seq.size() != 0) jobs_expected--;
            seq.delete();
            last_tile = '0;
        end else if (seq.size() == 0) begin
            if (st) build(n);
        end else if (!(stl && !seq[0].done)) begin
            last_tile = seq[0].tile_idx;
            void'(seq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_idle(input int pct);
        int guard;
        guard = 0;
        while (seq.size() != 0 && guard < 4000) begin
            tick(1'b0, 4'd0, ($urandom_range(0, 99) < pct), 1'b0);
            guard++;
        end
        if (seq.size() != 0) begin
            fails++;
            checks++;
            $display("FAIL job_timeout: job still pending after %0d cycles, required idle", guard);
            seq.delete();
        end
    endtask

    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            a = {busy, cnt, sa_reg_en, w_load, acc_clr, out_valid, tile_idx, done};
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL outputs t=%0t: got busy=%b cnt=%0d en=%b wl=%b clr=%b ov=%b tile=%0d done=%b, required busy=%b cnt=%0d en=%b wl=%b clr=%b ov=%b tile=%0d done=%b",
                         $time, a.busy, a.cnt, a.sa_reg_en, a.w_load, a.acc_clr,
                         a.out_valid, a.tile_idx, a.done, e.busy, e.cnt,
                         e.sa_reg_en, e.w_load, e.acc_clr, e.out_valid,
                         e.tile_idx, e.done);
            end
            if (primed && done === 1'b1) done_seen++;
        end
    end

    initial begin
        pat = '{1, 0, 1, 0, 0, 1, 0, 1, 1};
        checks = 0;
        fails = 0;
        jobs_expected = 0;
        done_seen = 0;
        last_tile = '0;
        primed = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        num_tiles = '0;
        @(posedge clk);
        #1;
        primed = 1'b1;
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        tick(1'b0, 4'd0, 1'b0, 1'b0);

        // abort mid-RUN at step 4
        tick(1'b1, 4'd2, 1'b0, 1'b0);
        repeat (6) tick(1'b0, 4'd0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 4'd0, 1'b0, 1'b0);

        tick(1'b1, 4'd1, 1'b0, 1'b0);
        run_to_idle(0);
        tick(1'b0, 4'd0, 1'b0, 1'b0);

        tick(1'b1, 4'd3, 1'b0, 1'b0);
        run_to_idle(0);
        tick(1'b0, 4'd0, 1'b0, 1'b0);

        // two stalled cycles at step 5
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        repeat (7) tick(1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) tick(1'b0, 4'd0, 1'b1, 1'b0);
        run_to_idle(0);

        tick(1'b1, 4'd0, 1'b0, 1'b0);
        run_to_idle(0);
        tick(1'b0, 4'd0, 1'b0, 1'b0);

        // start while busy is dropped; start right after done is taken
        tick(1'b1, 4'd2, 1'b0, 1'b0);
        repeat (5) tick(1'b1, 4'd3, 1'b0, 1'b0);
        run_to_idle(0);
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        run_to_idle(0);

        for (int j = 0; j < 30; j++) begin
            repeat ($urandom_range(0, 2)) tick(1'b0, 4'd0, 1'b0, 1'b0);
            tick(1'b1, 4'($urandom_range(0, 4)), 1'b0, 1'b0);
            run_to_idle(25);
        end

        tick(1'b1, 4'd15, 1'b0, 1'b0);
        run_to_idle(10);
        repeat (2) tick(1'b0, 4'd0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (done_seen != jobs_expected) begin
            fails++;
            $display("FAIL done_count: got %0d pulses, required %0d", done_seen, jobs_expected);
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sa_step_controller.md
Name: sa_step_controller

Overview:
Sequencer for the systolic-array (SA) compute pipeline. It runs a start/done job over a programmable number of tiles. For each tile it performs a weight-load phase, a 9-step compute phase and a drain phase. During compute it drives the 4-bit step count `cnt` and the SA register-enable pattern derived from it. It sits between the top-level job control and the SA datapath, and replaces free-running counters feeding the enable decoder.

Parameters:
- NUM_STEPS, 9: compute steps per tile; `cnt` runs 0..NUM_STEPS-1 (max 16).
- LOAD_CYCLES, 2: cycles of weight load per tile (>=1).
- DRAIN_CYCLES, 3: cycles of output drain per tile (>=1).
- TILE_W, 4: width of the tile count and tile index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- num_tiles  in  TILE_W  tiles in the job; latched when start is accepted.
- stall  in  1  freezes all counters and the FSM; gates pulses.
- busy  out  1  high in every state except IDLE.
- cnt  out  4  compute step index; 0 outside RUN.
- sa_reg_en  out  1  SA register enable.
- w_load  out  1  weight-load strobe.
- acc_clr  out  1  accumulator clear.
- out_valid  out  1  SA output valid.
- tile_idx  out  TILE_W  current tile, 0-based.
- done  out  1  one-cycle job-complete pulse.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, reset).
  - On reset: state=IDLE; cnt, phase counter, tile_idx and latched tile count are 0.
  - All outputs are 0 during and after reset until a start is accepted.
  - Reset asserted mid-job aborts it: IDLE on the next edge, no done pulse.
- Register structure: state, cnt, phase counter, tile_idx and the latched count are registers. Outputs decode combinationally from state, cnt and stall.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches num_tiles.
  - num_tiles!=0: go to LOAD, phase=0, tile_idx=0.
  - num_tiles==0: go straight to DONE (no LOAD/RUN/DRAIN).
- start while busy is ignored; it is not queued.
- LOAD:
  - w_load = ~stall.
  - Phase counter advances on non-stall cycles.
  - After LOAD_CYCLES advancing cycles: go to RUN, cnt=0.
- RUN:
  - cnt increments on each non-stall cycle.
  - sa_reg_en = pattern(cnt) & ~stall.
  - pattern, cnt 0..8 = 1,0,1,0,0,1,0,1,1; cnt 9..15 gives 0.
  - acc_clr = (cnt==0) & ~stall.
  - Non-stall cycle at cnt==NUM_STEPS-1: go to DRAIN, cnt=0, phase=0.
- DRAIN:
  - out_valid = ~stall.
  - After DRAIN_CYCLES advancing cycles:
    - if tile_idx == latched-1: go to DONE;
    - else tile_idx++ and go to LOAD (phase=0).
- DONE: done=1 for exactly one cycle, unaffected by stall; then IDLE.
  - tile_idx holds its last value until the next accepted start clears it.
- Stall: holds state, cnt and phase. Level outputs w_load, sa_reg_en, acc_clr and out_valid are forced 0. busy stays 1.
- Latency: a start accepted at edge E enters LOAD at E+1.
  - Per tile: LOAD_CYCLES + NUM_STEPS + DRAIN_CYCLES cycles with no stalls (14 at defaults).
  - done is asserted 1 + 14·N cycles after acceptance.
- num_tiles = 2^TILE_W-1 must complete without tile_idx wrap.

Test Plan:
- Reset mid-RUN (cnt=4) -> next cycle IDLE, busy=0, cnt=0, all outputs 0, no done pulse.
- start, num_tiles=1, no stall ->
  - w_load high cycles 1-2;
  - RUN cycles 3-11 with cnt 0..8 and sa_reg_en 1,0,1,0,0,1,0,1,1;
  - acc_clr at cycle 3 only;
  - out_valid cycles 12-14;
  - done at cycle 15; busy high cycles 1-15.
- num_tiles=3 -> tile_idx steps 0,1,2; three identical 14-cycle tile sequences; a single done at cycle 43.
- stall held 2 cycles at cnt=5 in RUN -> cnt stays 5 and sa_reg_en=0 while stalled; resumes with sa_reg_en=1 at cnt=5; done delayed exactly 2 cycles.
- num_tiles=0 -> DONE the next cycle: done pulse at cycle 1; w_load, sa_reg_en and out_valid never asserted.
- start re-pulsed while busy, then again in the cycle after done -> first ignored; second accepted and a new job runs.
